// File: rtl/eth_tlp_pkg.sv
// Shared types for the captured-TLP drain path.
//   tlp_fifo_word_t : 74-bit FIFO word {keep, data, last, user}, same layout as the tap writer
//   tlpgen_state_t  : drain FSM state
//   ABORT_WORD      : synthetic beat that closes a stalled frame so the MAC discards it
package eth_tlp_pkg;

  localparam int TLP_FIFO_W = 74;

  typedef struct packed {
    logic [7:0]  keep;
    logic [63:0] data;
    logic        last;
    logic        user;
  } tlp_fifo_word_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    ABORT,
    FLUSH
  } tlpgen_state_t;

  localparam tlp_fifo_word_t ABORT_WORD = '{keep: 8'h01, data: 64'h0, last: 1'b1, user: 1'b1};

endpackage

// File: rtl/eth_tlpgen_obuf.sv
// Circular output buffer between the FIFO capture point and the AXI4-Stream port.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/occupancy only)
//   push_i       : write push_word_i at the tail (ignored when full)
//   push_word_i  : word to store
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry (undefined content while occ_o == 0)
//   occ_o        : number of valid entries, 0..DEPTH
module eth_tlpgen_obuf
  import eth_tlp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  tlp_fifo_word_t             push_word_i,
  input  logic                       pop_i,
  output tlp_fifo_word_t             head_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  tlp_fifo_word_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (occ_q != '0);
  assign do_push = push_i && (occ_q != OCC_W'(DEPTH));

  // Storage carries no reset; the top gates the stream outputs with occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_word_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/eth_tlpgen.sv
// Drain side of the captured-TLP FIFO: reads 74-bit words from a standard
// (1-cycle read latency) FIFO and replays them as a 64-bit AXI4-Stream toward
// the 10G MAC. Frames that stall mid-packet are closed with an abort beat and
// their tail is flushed from the FIFO.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   rd_en / dout      : FIFO read strobe, word valid on dout the following cycle
//   empty             : FIFO empty
//   m_axis_*          : stream master; beat transfers when tvalid && tready
//   pkt_cnt           : packets completed normally (wraps)
//   err_cnt           : packets aborted (saturates)
//   dbg_state_o       : current drain FSM state
// Handshake: m_axis_tvalid never depends on m_axis_tready; once tvalid is high
// the beat (data/keep/last/user) is held until the cycle tready is sampled high.
module eth_tlpgen
  import eth_tlp_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 64,
  parameter int OBUF_DEPTH       = 4,
  parameter int UNDERRUN_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      rd_en,
  input  logic [TLP_FIFO_W-1:0]     dout,
  input  logic                      empty,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [7:0]                m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [31:0]               pkt_cnt,
  output logic [15:0]               err_cnt,
  output tlpgen_state_t             dbg_state_o
);

  localparam int OCC_W = $clog2(OBUF_DEPTH) + 1;

  tlp_fifo_word_t   in_word;
  tlp_fifo_word_t   push_word;
  tlp_fifo_word_t   head;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   credit_used;
  logic             push;
  logic             pop;
  logic             inflight_q;
  tlpgen_state_t    state_q;
  logic [7:0]       stall_q;
  logic [31:0]      pkt_q;
  logic [15:0]      err_q;

  assign in_word     = tlp_fifo_word_t'(dout);
  // Entries already held plus the one word that may be on its way from the FIFO.
  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};

  always_comb begin
    rd_en     = 1'b0;
    push      = 1'b0;
    push_word = in_word;
    unique case (state_q)
      IDLE, STREAM: begin
        rd_en = !empty && (credit_used < (OCC_W + 1)'(OBUF_DEPTH));
        push  = inflight_q;
      end
      ABORT: begin
        push      = (occ < OCC_W'(OBUF_DEPTH));
        push_word = ABORT_WORD;
      end
      FLUSH: begin
        // No new read while the terminating word is being captured: the next
        // word belongs to a new frame and must arrive under IDLE credit rules.
        rd_en = !empty && !(inflight_q && in_word.last);
      end
      default: ;
    endcase
    if (!rst_n) rd_en = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stall_q    <= '0;
      pkt_q      <= '0;
      err_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      unique case (state_q)
        IDLE: begin
          if (push) begin
            stall_q <= '0;
            if (in_word.last) pkt_q   <= pkt_q + 32'd1;
            else              state_q <= STREAM;
          end
        end
        STREAM: begin
          if (push) begin
            stall_q <= '0;
            if (in_word.last) begin
              pkt_q   <= pkt_q + 32'd1;
              state_q <= IDLE;
            end
          end else if (empty && !inflight_q) begin
            // A counted cycle never has a read outstanding, so ABORT starts
            // with nothing inflight.
            if (stall_q == 8'(UNDERRUN_TIMEOUT - 1)) begin
              stall_q <= '0;
              state_q <= ABORT;
            end else begin
              stall_q <= stall_q + 8'd1;
            end
          end
        end
        ABORT: begin
          if (push) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (inflight_q && in_word.last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  eth_tlpgen_obuf #(
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_word_i (push_word),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign m_axis_tvalid = (occ != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? C_DATA_WIDTH'(head.data) : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head.keep : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid && head.last;
  assign m_axis_tuser  = m_axis_tvalid && head.user;

  assign pkt_cnt     = pkt_q;
  assign err_cnt     = err_q;
  assign dbg_state_o = state_q;

endmodule
